// File: rtl/ram_mem_arbiter.sv
// ram_mem_arbiter: shares one byte-addressed RAM between an instruction-fetch
// port (word reads) and a data port (byte/half/word, read/write, optional sign
// extension). It drives the RAM's MOV/MOC/MOCoff handshake and filters out
// misaligned, out-of-range or bad-size requests before the RAM sees them.
// Optional feature: define RAM_ARB_TIMEOUT_EN to abort accesses that sit in
// WAIT/REL for TIMEOUT cycles.
module ram_mem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 256,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        FReq,
    input  logic [31:0] FAddr,
    output logic        FAck,
    output logic [31:0] FData,
    output logic        FErr,
    input  logic        DReq,
    input  logic        DReadWrite,
    input  logic [2:0]  DMS_2_0,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic        DAck,
    output logic [31:0] DRData,
    output logic        DErr,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    output logic        MOCoff,
    input  logic        MOC,
    input  logic [31:0] DataOut
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] FETCH_MS = 3'b010;

    // Size/alignment/range screen; the last byte is computed in 33 bits so
    // addresses near 2^32 cannot wrap back into range.
    function automatic logic req_valid(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] last_byte;
        logic        aligned;
        case (size)
            2'b00:   begin aligned = 1'b1;                last_byte = {1'b0, addr};          end
            2'b01:   begin aligned = (addr[0] == 1'b0);   last_byte = {1'b0, addr} + 33'd1;  end
            2'b10:   begin aligned = (addr[1:0] == 2'b00); last_byte = {1'b0, addr} + 33'd3; end
            default: begin aligned = 1'b0;                last_byte = 33'd0;                 end
        endcase
        return aligned && (last_byte < 33'(ADDR_LIMIT));
    endfunction

    // Right-justified read data, optionally sign-extended from the access size.
    function automatic logic [31:0] rd_extend(input logic [31:0] raw, input logic [2:0] ms);
        case (ms[1:0])
            2'b00:   return {{24{ms[2] & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{ms[2] & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;   // 1 = data port was granted last
    logic        gnt_data_q, gnt_data_d;   // 1 = current access belongs to data port
    logic        mov_q, mov_d, mocoff_q, mocoff_d, rw_q, rw_d;
    logic [2:0]  ms_q, ms_d;
    logic [31:0] addr_q, addr_d, din_q, din_d, rd_buf_q, rd_buf_d;
    logic        fack_q, fack_d, ferr_q, ferr_d, dack_q, dack_d, derr_q, derr_d;
    logic [31:0] fdata_q, fdata_d, drdata_q, drdata_d;

    logic        pick_data_s, any_req_s, req_ok_s, req_rw_s, tmo_hit_s;
    logic        ack_s, err_s, ack_to_data_s;
    logic [2:0]  req_ms_s;
    logic [31:0] req_addr_s, req_wdata_s;

    // Round-robin pick between the two ports and screening of the winner.
    always_comb begin
        any_req_s   = FReq | DReq;
        pick_data_s = DReq & (~FReq | ~last_gnt_q);
        if (pick_data_s) begin
            req_addr_s  = DAddr;
            req_ms_s    = DMS_2_0;
            req_rw_s    = DReadWrite;
            req_wdata_s = DWData;
        end else begin
            req_addr_s  = FAddr;
            req_ms_s    = FETCH_MS;
            req_rw_s    = 1'b1;
            req_wdata_s = 32'd0;
        end
        req_ok_s = req_valid(req_addr_s, req_ms_s[1:0]);
    end

`ifdef RAM_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Cycle counter: held at zero in IDLE so it starts cleared on entry to WAIT.
    always_comb begin
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = 8'd0;
        end else if ((state_q == ST_WAIT) || (state_q == ST_REL)) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Timeout counter register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign tmo_hit_s = ((state_q == ST_WAIT) || (state_q == ST_REL)) &&
                       (tmo_cnt_q == 8'(TIMEOUT - 32'd1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state logic of the RAM handshake sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!MOC && any_req_s) begin
                    state_d = req_ok_s ? ST_WAIT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (MOC) begin
                    state_d = ST_REL;
                end else if (tmo_hit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_REL: begin
                if (!MOC || tmo_hit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of all registered outputs and the latched access.
    always_comb begin
        last_gnt_d    = last_gnt_q;
        gnt_data_d    = gnt_data_q;
        mov_d         = mov_q;
        mocoff_d      = mocoff_q;
        rw_d          = rw_q;
        ms_d          = ms_q;
        addr_d        = addr_q;
        din_d         = din_q;
        rd_buf_d      = rd_buf_q;
        fdata_d       = fdata_q;
        drdata_d      = drdata_q;
        ack_s         = 1'b0;
        err_s         = 1'b0;
        ack_to_data_s = gnt_data_q;
        case (state_q)
            ST_IDLE: begin
                if (MOC) begin
                    mocoff_d = 1'b1;          // stale MOC: release before any grant
                end else begin
                    mocoff_d = 1'b0;
                    if (any_req_s) begin
                        gnt_data_d = pick_data_s;
                        if (req_ok_s) begin
                            mov_d      = 1'b1;
                            rw_d       = req_rw_s;
                            ms_d       = req_ms_s;
                            addr_d     = req_addr_s;
                            din_d      = req_wdata_s;
                            last_gnt_d = pick_data_s;
                        end else begin
                            ack_s         = 1'b1;
                            err_s         = 1'b1;
                            ack_to_data_s = pick_data_s;
                        end
                    end else begin
                        gnt_data_d = gnt_data_q;
                    end
                end
            end
            ST_WAIT: begin
                if (MOC) begin
                    rd_buf_d = DataOut;
                    mov_d    = 1'b0;
                    mocoff_d = 1'b1;
                end else if (tmo_hit_s) begin
                    mov_d    = 1'b0;
                    mocoff_d = 1'b1;
                    ack_s    = 1'b1;
                    err_s    = 1'b1;
                end else begin
                    mov_d = 1'b1;
                end
            end
            ST_REL: begin
                if (!MOC) begin
                    mocoff_d = 1'b0;
                    ack_s    = 1'b1;
                    if (!gnt_data_q) begin
                        fdata_d = rd_buf_q;
                    end else if (rw_q) begin
                        drdata_d = rd_extend(rd_buf_q, ms_q);
                    end else begin
                        drdata_d = drdata_q;
                    end
                end else if (tmo_hit_s) begin
                    mocoff_d = 1'b1;
                    ack_s    = 1'b1;
                    err_s    = 1'b1;
                end else begin
                    mocoff_d = 1'b1;
                end
            end
            ST_DONE: ack_s = 1'b0;
            default: ack_s = 1'b0;
        endcase
        fack_d = ack_s & ~ack_to_data_s;
        ferr_d = err_s & ~ack_to_data_s;
        dack_d = ack_s & ack_to_data_s;
        derr_d = err_s & ack_to_data_s;
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b0;
            gnt_data_q <= 1'b0;
            mov_q      <= 1'b0;
            mocoff_q   <= 1'b0;
            rw_q       <= 1'b0;
            ms_q       <= 3'd0;
            addr_q     <= 32'd0;
            din_q      <= 32'd0;
            rd_buf_q   <= 32'd0;
            fack_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dack_q     <= 1'b0;
            derr_q     <= 1'b0;
            fdata_q    <= 32'd0;
            drdata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_data_q <= gnt_data_d;
            mov_q      <= mov_d;
            mocoff_q   <= mocoff_d;
            rw_q       <= rw_d;
            ms_q       <= ms_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_buf_q   <= rd_buf_d;
            fack_q     <= fack_d;
            ferr_q     <= ferr_d;
            dack_q     <= dack_d;
            derr_q     <= derr_d;
            fdata_q    <= fdata_d;
            drdata_q   <= drdata_d;
        end
    end

    assign MOV       = mov_q;
    assign MOCoff    = mocoff_q;
    assign ReadWrite = rw_q;
    assign MS_2_0    = ms_q;
    assign Address   = addr_q;
    assign DataIn    = din_q;
    assign FAck      = fack_q;
    assign FErr      = ferr_q;
    assign FData     = fdata_q;
    assign DAck      = dack_q;
    assign DErr      = derr_q;
    assign DRData    = drdata_q;

endmodule

// File: doc/ram_mem_arbiter.md
# ram_mem_arbiter

Two-port clocked arbiter and handshake sequencer in front of the byte-addressed 256x8 RAM. It shares the RAM between an instruction-fetch port (word reads only) and a data port (byte/halfword/word, read/write, optional sign extension). It drives the RAM's MOV/ReadWrite/MS_2_0/MOCoff protocol and waits on MOC. It rejects misaligned, out-of-range or unsupported-size requests without touching the RAM.

## Interface
- ADDR_LIMIT, 256, first invalid byte address; any access whose last byte is at or above this is rejected.
- TIMEOUT, 64, cycles allowed in WAIT or REL before abort (only with RAM_ARB_TIMEOUT_EN).

- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- FReq  in  1  fetch request; hold stable until FAck.
- FAddr  in  32  fetch byte address, word-aligned.
- FAck  out  1  one-cycle completion pulse for fetch.
- FData  out  32  fetched word, valid while FAck=1 and held until the next fetch FAck.
- FErr  out  1  qualifies FAck: request rejected or aborted.
- DReq  in  1  data request; hold stable until DAck.
- DReadWrite  in  1  1=read, 0=write.
- DMS_2_0  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 invalid; [2] sign-extend on reads.
- DAddr  in  32  data byte address.
- DWData  in  32  write data, right-justified.
- DAck  out  1  one-cycle completion pulse for data.
- DRData  out  32  read data, valid with DAck.
- DErr  out  1  qualifies DAck.
- MOV, ReadWrite, MS_2_0[3], Address[32], DataIn[32], MOCoff  out  to RAM.
- MOC  in  1  RAM operation complete.
- DataOut  in  32  RAM read bus.

## Operation
- States: IDLE, WAIT, REL, DONE. All outputs are registered.
- IDLE with MOC=1 (stale MOC after reset or abort):
  - drive MOCoff=1 and grant nothing until MOC=0;
  - then MOCoff=0.
- IDLE with a request pending:
  - Arbitrate with a round-robin pointer LastGnt. When both ports request, grant the port that is not LastGnt.
  - Reset value LastGnt=fetch, so the data port wins the first tie.
  - Fetch is issued as a word read: ReadWrite=1, MS_2_0=3'b010.
- Validity check on the granted request:
  - reject if size is 11;
  - reject if half and Address[0]≠0;
  - reject if word and Address[1:0]≠0;
  - reject if Address+bytes−1 ≥ ADDR_LIMIT (compute in 33 bits to avoid wrap);
  - a rejected request goes straight to DONE with Ack=1, Err=1. MOV is never asserted.
- Valid request: latch Address/DataIn/MS_2_0/ReadWrite, set MOV=1, go to WAIT. Update LastGnt.
- WAIT: when MOC=1, capture DataOut into the granted port's read register, set MOV=0 and MOCoff=1, go to REL.
- REL: when MOC=0, set MOCoff=0 and pulse Ack for the granted port (Err=0), go to DONE.
- DONE: one cycle, then IDLE. Requests are not sampled in DONE. A requester must drop or change Req by the end of its Ack cycle.
- A requester changing inputs while unacknowledged is illegal. The controller uses only the values latched at grant.
- Reset (at any time, including mid-operation):
  - state IDLE;
  - MOV=0, MOCoff=0, ReadWrite=0, MS_2_0=0, Address=0, DataIn=0;
  - FAck=DAck=0, FErr=DErr=0, FData=DRData=0;
  - LastGnt=fetch.

## Timing
- Request sampled in IDLE at edge k.
- Accepted access:
  - MOV=1 after edge k;
  - MOC seen at edge k+1 at the earliest, giving MOV=0 and MOCoff=1;
  - MOC=0 seen at edge k+2, giving Ack=1;
  - IDLE again after edge k+3.
- Minimum latency is 3 cycles to Ack; minimum back-to-back issue period is 4 cycles.
- Each extra cycle of MOC delay adds one cycle.
- Rejected access: Ack/Err after edge k, IDLE after edge k+1.
- Only one Ack is ever high in a cycle. The RAM sees at most one MOV=1 window per grant.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - an 8-bit counter clears on entry to WAIT and counts in WAIT/REL;
  - on reaching TIMEOUT, set MOV=0, MOCoff=1, pulse Ack with Err=1, go to DONE;
  - the stale-MOC clearing in IDLE then finishes the release.
- RAM_ARB_TIMEOUT_EN undefined: no counter; WAIT and REL wait indefinitely.

## Test plan
- Data word write 0xDEADBEEF to 0x10, then fetch from 0x10 → FAck with FErr=0 and FData=0xDEADBEEF, exactly 3 cycles after the fetch grant.
- Data byte write 0x80 to 0x21, then read with DMS_2_0=3'b100 → DRData=0xFFFFFF80; same read with DMS_2_0=3'b000 → DRData=0x00000080.
- FReq and DReq asserted together and held for two transactions → data acked first, then fetch. After a reset mid-second-transaction, all outputs are 0 and the data port wins the next tie again.
- Each of the following → DAck=1, DErr=1 one cycle after the sample edge, and MOV never rises:
  - half at 0x03;
  - word at 0x06;
  - word at 0xFE;
  - size 11.
- Reset asserted with MOC held 1 → after release, MOCoff=1 and no grant until MOC=0; a pending DReq is then granted.
- With RAM_ARB_TIMEOUT_EN and TIMEOUT=8, MOC tied 0 → DAck with DErr=1 exactly 8 cycles after entering WAIT, with MOV=0.
